// File: rtl/tx_arb_if.sv
// Word-request / byte-strobe bundle shared by tx_arb and its requesters.
// The slave modport is the arbiter's view. The master modport is the requester and UART side.
interface tx_arb_if;
    logic [1:0]  req_stb_i;
    logic [31:0] req_data0_i;
    logic [31:0] req_data1_i;
    logic [2:0]  req_width0_i;
    logic [2:0]  req_width1_i;
    logic [1:0]  req_rdy_o;
    logic [7:0]  byte_o;
    logic        byte_stb_o;
    logic        byte_rdy_i;
    logic        busy_o;
    logic        ovf_o;

    modport slave (
        input  req_stb_i, req_data0_i, req_data1_i, req_width0_i, req_width1_i, byte_rdy_i,
        output req_rdy_o, byte_o, byte_stb_o, busy_o, ovf_o
    );

    modport master (
        output req_stb_i, req_data0_i, req_data1_i, req_width0_i, req_width1_i, byte_rdy_i,
        input  req_rdy_o, byte_o, byte_stb_o, busy_o, ovf_o
    );
endinterface

// File: rtl/tx_arb.sv
// Two-requester round-robin word arbiter in front of the UART byte transmitter.
// Each requester has a one-word slot. The granted word is sent LSB-first as byte strobes.
//
// state | meaning
// IDLE  | shifter empty; grant a full slot if there is one
// SEND  | byte pending; strobe it when the UART reports idle
// GAP   | one dead cycle after each strobe while the UART drops byte_rdy_i
module tx_arb #(
    parameter int WIDTH = 32
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     clr_i,
    tx_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t             state;
    logic [1:0]         slot_full;
    logic [WIDTH-1:0]   slot_data [2];
    logic [2:0]         slot_width [2];
    logic [WIDTH-1:0]   shifter;
    logic [2:0]         count;
    logic               last_grant;
    logic [7:0]         byte_q;
    logic               ovf_q;

    logic               grant_vld;
    logic               grant_idx;
    logic               send_fire;
    logic [WIDTH-1:0]   in_data [2];
    logic [2:0]         in_width [2];

    function automatic logic [2:0] clamp_width(input logic [2:0] w);
        return (w > 3'd4) ? 3'd4 : w;
    endfunction

    always_comb begin
        in_data[0]  = bus.req_data0_i;
        in_data[1]  = bus.req_data1_i;
        in_width[0] = clamp_width(bus.req_width0_i);
        in_width[1] = clamp_width(bus.req_width1_i);
    end

    // Both slots full: hand the turn to the requester that was not served last.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        if (state == ST_IDLE) begin
            case (slot_full)
                2'b01:   begin grant_vld = 1'b1; grant_idx = 1'b0;        end
                2'b10:   begin grant_vld = 1'b1; grant_idx = 1'b1;        end
                2'b11:   begin grant_vld = 1'b1; grant_idx = ~last_grant; end
                default: begin grant_vld = 1'b0; grant_idx = 1'b0;        end
            endcase
        end
    end

    assign send_fire = (state == ST_SEND) && bus.byte_rdy_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            slot_full     <= 2'b00;
            slot_data[0]  <= '0;
            slot_data[1]  <= '0;
            slot_width[0] <= '0;
            slot_width[1] <= '0;
            shifter       <= '0;
            count         <= '0;
            last_grant    <= 1'b1;
            byte_q        <= '0;
            ovf_q         <= 1'b0;
        end else begin
            // Slot fullness is judged at cycle start, so a strobe into a slot being granted is an overflow.
            for (int k = 0; k < 2; k++) begin
                if (clr_i) begin
                    slot_full[k] <= 1'b0;
                end else if (bus.req_stb_i[k] && !slot_full[k]) begin
                    slot_full[k]  <= 1'b1;
                    slot_data[k]  <= in_data[k];
                    slot_width[k] <= in_width[k];
                end else if (grant_vld && (grant_idx == 1'(k))) begin
                    slot_full[k] <= 1'b0;
                end
            end

            if (clr_i)
                ovf_q <= 1'b0;
            else if (|(bus.req_stb_i & slot_full))
                ovf_q <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        shifter    <= slot_data[grant_idx];
                        byte_q     <= slot_data[grant_idx][7:0];
                        count      <= slot_width[grant_idx];
                        last_grant <= grant_idx;
                        state      <= (slot_width[grant_idx] != 3'd0) ? ST_SEND : ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (bus.byte_rdy_i) begin
                        shifter <= shifter >> 8;
                        byte_q  <= shifter[15:8];
                        count   <= count - 3'd1;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state <= (count != 3'd0) ? ST_SEND : ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // byte_q always mirrors shifter[7:0], so the strobe can fire in the SEND cycle itself.
    assign bus.byte_o     = byte_q;
    assign bus.byte_stb_o = send_fire;
    assign bus.req_rdy_o  = ~slot_full;
    assign bus.busy_o     = (state != ST_IDLE) || (|slot_full);
    assign bus.ovf_o      = ovf_q;

endmodule

// File: tb/tb_tx_arb.sv
// Directed bench for tx_arb: each scenario task drives words and checks strobes, bytes and flags.
module tb_tx_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [7:0] q_byte [$];
    int         q_cyc  [$];
    logic       prev_stb = 1'b0;
    bit         consec = 1'b0;

    tx_arb_if bus();

    tx_arb dut (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (clr),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.byte_stb_o === 1'b1) begin
            q_byte.push_back(bus.byte_o);
            q_cyc.push_back(cyc);
            if (prev_stb) consec = 1'b1;
        end
        prev_stb = (bus.byte_stb_o === 1'b1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        q_byte.delete();
        q_cyc.delete();
        consec = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_stb_i    = 2'b00;
        bus.req_data0_i  = '0;
        bus.req_data1_i  = '0;
        bus.req_width0_i = '0;
        bus.req_width1_i = '0;
        bus.byte_rdy_i   = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_rdy_o !== 2'b11) begin errors++; $display("FAIL reset_rdy: got %b expected 11", bus.req_rdy_o); end
        checks++; if (bus.byte_o !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h expected 00", bus.byte_o); end
        checks++; if (bus.byte_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", bus.byte_stb_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
        checks++; if (bus.ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf_o); end
    endtask

    task automatic test_single();
        int t0;
        logic [7:0] eb [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        clear_log();
        step();
        bus.req_stb_i = 2'b10; bus.req_data1_i = 32'hDDCCBBAA; bus.req_width1_i = 3'd4;
        t0 = cyc;
        step();
        bus.req_stb_i = 2'b00;
        @(negedge clk);
        checks++; if (bus.req_rdy_o !== 2'b01) begin errors++; $display("FAIL single_rdy_t1: got %b expected 01", bus.req_rdy_o); end
        step();
        @(negedge clk);
        checks++; if (bus.req_rdy_o !== 2'b11) begin errors++; $display("FAIL single_rdy_t2: got %b expected 11", bus.req_rdy_o); end
        repeat (10) step();
        checks++; if (q_byte.size() != 4) begin errors++; $display("FAIL single_count: got %0d expected 4", q_byte.size()); end
        for (int i = 0; i < 4 && i < q_byte.size(); i++) begin
            checks++;
            if (q_byte[i] !== eb[i] || q_cyc[i] != t0 + 2 + 2*i) begin
                errors++;
                $display("FAIL single_byte%0d: got %h at t+%0d expected %h at t+%0d", i, q_byte[i], q_cyc[i]-t0, eb[i], 2+2*i);
            end
        end
    endtask

    task automatic test_both();
        int t0;
        logic [7:0] eb [3] = '{8'h11, 8'h22, 8'h22};
        int         ec [3] = '{2, 5, 7};
        clear_log();
        step();
        bus.req_stb_i = 2'b11;
        bus.req_data0_i = 32'h00000011; bus.req_width0_i = 3'd1;
        bus.req_data1_i = 32'h00002222; bus.req_width1_i = 3'd2;
        t0 = cyc;
        step();
        bus.req_stb_i = 2'b00;
        repeat (12) step();
        checks++; if (q_byte.size() != 3) begin errors++; $display("FAIL both_count: got %0d expected 3", q_byte.size()); end
        for (int i = 0; i < 3 && i < q_byte.size(); i++) begin
            checks++;
            if (q_byte[i] !== eb[i] || q_cyc[i] != t0 + ec[i]) begin
                errors++;
                $display("FAIL both_byte%0d: got %h at t+%0d expected %h at t+%0d", i, q_byte[i], q_cyc[i]-t0, eb[i], ec[i]);
            end
        end
        checks++; if (bus.ovf_o !== 1'b0) begin errors++; $display("FAIL both_ovf: got %b expected 0", bus.ovf_o); end
    endtask

    task automatic test_overflow_clr();
        logic [7:0] eb [2] = '{8'h66, 8'h77};
        clear_log();
        bus.byte_rdy_i = 1'b0;
        step();
        bus.req_stb_i = 2'b01; bus.req_data0_i = 32'h00007766; bus.req_width0_i = 3'd2;
        step();
        bus.req_stb_i = 2'b00;
        step();
        step();
        bus.req_stb_i = 2'b10; bus.req_data1_i = 32'h00000055; bus.req_width1_i = 3'd1;
        step();
        bus.req_stb_i = 2'b00;
        @(negedge clk);
        checks++; if (bus.req_rdy_o !== 2'b01) begin errors++; $display("FAIL ovf_rdy_full: got %b expected 01", bus.req_rdy_o); end
        checks++; if (bus.ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b expected 0", bus.ovf_o); end
        step();
        bus.req_stb_i = 2'b10; bus.req_data1_i = 32'h00000099;
        step();
        bus.req_stb_i = 2'b00;
        @(negedge clk);
        checks++; if (bus.ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus.ovf_o); end
        step();
        clr = 1'b1;
        bus.req_stb_i = 2'b01; bus.req_data0_i = 32'h000000EE; bus.req_width0_i = 3'd1;
        step();
        clr = 1'b0;
        bus.req_stb_i = 2'b00;
        @(negedge clk);
        checks++; if (bus.ovf_o !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b expected 0", bus.ovf_o); end
        checks++; if (bus.req_rdy_o !== 2'b11) begin errors++; $display("FAIL clr_rdy: got %b expected 11", bus.req_rdy_o); end
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL clr_busy: got %b expected 1", bus.busy_o); end
        bus.byte_rdy_i = 1'b1;
        repeat (8) step();
        checks++; if (q_byte.size() != 2) begin errors++; $display("FAIL clr_count: got %0d expected 2", q_byte.size()); end
        for (int i = 0; i < 2 && i < q_byte.size(); i++) begin
            checks++;
            if (q_byte[i] !== eb[i]) begin errors++; $display("FAIL clr_byte%0d: got %h expected %h", i, q_byte[i], eb[i]); end
        end
        checks++; if (bus.ovf_o !== 1'b0) begin errors++; $display("FAIL clr_ovf_end: got %b expected 0", bus.ovf_o); end
    endtask

    task automatic test_backpressure();
        int t0;
        logic [7:0] eb [3] = '{8'hA1, 8'hA2, 8'hA3};
        int         ec [3] = '{2, 13, 15};
        clear_log();
        bus.byte_rdy_i = 1'b1;
        step();
        bus.req_stb_i = 2'b01; bus.req_data0_i = 32'h00A3A2A1; bus.req_width0_i = 3'd3;
        t0 = cyc;
        step();
        bus.req_stb_i = 2'b00;
        step();
        step();
        bus.byte_rdy_i = 1'b0;
        repeat (10) step();
        checks++; if (q_byte.size() != 1) begin errors++; $display("FAIL bp_hold_count: got %0d expected 1", q_byte.size()); end
        bus.byte_rdy_i = 1'b1;
        repeat (8) step();
        checks++; if (q_byte.size() != 3) begin errors++; $display("FAIL bp_count: got %0d expected 3", q_byte.size()); end
        for (int i = 0; i < 3 && i < q_byte.size(); i++) begin
            checks++;
            if (q_byte[i] !== eb[i] || q_cyc[i] != t0 + ec[i]) begin
                errors++;
                $display("FAIL bp_byte%0d: got %h at t+%0d expected %h at t+%0d", i, q_byte[i], q_cyc[i]-t0, eb[i], ec[i]);
            end
        end
        checks++; if (consec !== 1'b0) begin errors++; $display("FAIL bp_consec: got %b expected 0", consec); end
    endtask

    task automatic test_width();
        int t0;
        logic [7:0] eb [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        clear_log();
        step();
        bus.req_stb_i = 2'b01; bus.req_data0_i = 32'hFFFFFFFF; bus.req_width0_i = 3'd0;
        t0 = cyc;
        step();
        bus.req_stb_i = 2'b10; bus.req_data1_i = 32'h44332211; bus.req_width1_i = 3'd7;
        step();
        bus.req_stb_i = 2'b00;
        @(negedge clk);
        checks++; if (bus.req_rdy_o !== 2'b01) begin errors++; $display("FAIL width_rdy: got %b expected 01", bus.req_rdy_o); end
        repeat (10) step();
        checks++; if (q_byte.size() != 4) begin errors++; $display("FAIL width_count: got %0d expected 4", q_byte.size()); end
        for (int i = 0; i < 4 && i < q_byte.size(); i++) begin
            checks++;
            if (q_byte[i] !== eb[i] || q_cyc[i] != t0 + 3 + 2*i) begin
                errors++;
                $display("FAIL width_byte%0d: got %h at t+%0d expected %h at t+%0d", i, q_byte[i], q_cyc[i]-t0, eb[i], 3+2*i);
            end
        end
    endtask

    task automatic test_reset_midword();
        int t0;
        clear_log();
        step();
        bus.req_stb_i = 2'b10; bus.req_data1_i = 32'h88776655; bus.req_width1_i = 3'd4;
        step();
        bus.req_data1_i = 32'h12345678;
        step();
        bus.req_stb_i = 2'b00;
        @(negedge clk);
        checks++; if (bus.ovf_o !== 1'b1) begin errors++; $display("FAIL grant_cycle_ovf: got %b expected 1", bus.ovf_o); end
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_rdy_o !== 2'b11) begin errors++; $display("FAIL rst_mid_rdy: got %b expected 11", bus.req_rdy_o); end
        checks++; if (bus.byte_o !== 8'h00) begin errors++; $display("FAIL rst_mid_byte: got %h expected 00", bus.byte_o); end
        checks++; if (bus.byte_stb_o !== 1'b0) begin errors++; $display("FAIL rst_mid_stb: got %b expected 0", bus.byte_stb_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy_o); end
        checks++; if (bus.ovf_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf: got %b expected 0", bus.ovf_o); end
        repeat (8) step();
        checks++; if (q_byte.size() != 2) begin errors++; $display("FAIL rst_mid_count: got %0d expected 2", q_byte.size()); end
        clear_log();
        step();
        bus.req_stb_i = 2'b01; bus.req_data0_i = 32'h000000C3; bus.req_width0_i = 3'd1;
        t0 = cyc;
        step();
        bus.req_stb_i = 2'b00;
        repeat (6) step();
        checks++; if (q_byte.size() != 1) begin errors++; $display("FAIL after_rst_count: got %0d expected 1", q_byte.size()); end
        if (q_byte.size() > 0) begin
            checks++;
            if (q_byte[0] !== 8'hC3 || q_cyc[0] != t0 + 2) begin
                errors++;
                $display("FAIL after_rst_byte: got %h at t+%0d expected c3 at t+2", q_byte[0], q_cyc[0]-t0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_overflow_clr();
        test_backpressure();
        test_width();
        test_reset_midword();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_arb.md
Name: tx_arb

Overview:
- Shares the single UART byte transmitter between two word-level requesters.
  - Requester 0: command responder (ID/metadata replies).
  - Requester 1: sample readback from the main capture FSM.
- Each requester hands over one word of up to 4 bytes plus a byte count.
- The block buffers one word per requester, arbitrates round-robin, and serialises the granted word LSB-first into byte strobes for the UART transmitter.

Parameters:
- WIDTH, 32, word width in bits; fixed at 32, WIDTH/8 = 4 byte lanes.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active high.
- clr_i  in  1  synchronous flush: drops pending slots and clears ovf_o; does not abort a word already in the shifter.
- req_stb_i  in  2  per-requester single-cycle word strobe.
- req_data0_i  in  WIDTH  requester 0 word.
- req_data1_i  in  WIDTH  requester 1 word.
- req_width0_i  in  3  requester 0 byte count, 0..4.
- req_width1_i  in  3  requester 1 byte count, 0..4.
- req_rdy_o  out  2  per-requester slot-empty flag (registered).
- byte_o  out  8  byte to UART transmitter.
- byte_stb_o  out  1  single-cycle byte strobe.
- byte_rdy_i  in  1  UART idle flag; drops the cycle after an accepted strobe.
- busy_o  out  1  shifter active, or any slot full.
- ovf_o  out  1  sticky: a strobe arrived while its slot was full.

Behaviour:
- Reset (rst_i=1): state IDLE, both slots empty, shifter and byte count 0, last_grant=1.
  - Outputs: req_rdy_o=2'b11, byte_o=0, byte_stb_o=0, busy_o=0, ovf_o=0.
  - Reset mid-word abandons the word; no further byte strobes are issued.
- Slot k capture:
  - If req_stb_i[k]=1 and slot k is empty at the start of the cycle, latch data and width; req_rdy_o[k]=0 from the next cycle.
  - If the slot is full, the word is dropped and ovf_o=1 from the next cycle, held until clr_i or reset.
- Width rule: width>4 is clamped to 4. A width 0 word is accepted, frees its slot at grant, and emits no byte.
- States: IDLE, SEND, GAP.
- IDLE:
  - No slot full: stay.
  - One slot full: grant it.
  - Both full: grant the slot != last_grant.
  - On grant: load shifter with word and count, clear the slot (req_rdy_o[k]=1 next cycle), last_grant<=k.
  - Next state SEND if count>0, else stay IDLE.
- SEND:
  - If byte_rdy_i=1: byte_stb_o=1 with byte_o=shifter[7:0]; shifter >>= 8; count--; go to GAP.
  - Else hold.
- GAP: one cycle, byte_rdy_i ignored. Then SEND if count>0, else IDLE.
- Output registers:
  - byte_o is a registered copy of shifter[7:0]; it is stable while byte_stb_o=1.
  - byte_stb_o is never high on consecutive cycles.
- Latency: req strobe at cycle t with the UART idle gives the first byte_stb_o at t+2; subsequent bytes follow every 2 cycles minimum.
- Simultaneous events:
  - Strobes on both requesters in the same cycle: both captured.
  - Strobe to slot k in the same cycle slot k is granted: dropped, ovf_o set. The slot is judged full at cycle start.
- clr_i:
  - Empties both slots and clears ovf_o.
  - A word in the shifter completes normally.
  - clr_i and req_stb_i in the same cycle: clr wins; the strobe is dropped without setting ovf_o.
- Grant is non-preemptive: a granted word always emits all its bytes before the next grant.

Test Plan:
- Requester 1 sends data=0xDDCCBBAA, width=4, byte_rdy_i tied 1 -> byte_o sequence AA,BB,CC,DD; strobes at t+2,t+4,t+6,t+8; req_rdy_o[1]=1 from t+2.
- Both requesters strobe in the same cycle: r0=0x11 w=1, r1=0x2222 w=2; last_grant=1 after reset -> order 11, then 22,22; ovf_o stays 0.
- Requester 1 strobes twice while its slot is full -> second word dropped, ovf_o=1; clr_i pulse -> ovf_o=0, slot empty.
- byte_rdy_i held low 10 cycles after the first byte of a 3-byte word -> no strobe during hold; remaining two bytes emitted after rdy returns; byte_stb_o never high on consecutive cycles.
- Width 0 word, then width 7 word 0x44332211 -> no byte for the first; the second emits exactly 11,22,33,44.
- rst_i asserted after the second byte of a 4-byte word -> no further strobes; all outputs return to their reset values the next cycle; a new word is serviced normally afterwards.
